// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode controls and data into EX, with optional load-use bubble insertion (ID_EX_HAZARD_EN).
// Latency: 1 cycle. Backpressure: stallIn holds everything, flushIn or a load-use hazard inserts a bubble, hazardStall freezes upstream.
// Bubble counter saturates at all-ones.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 2,
    parameter int MEM_CTRL_WIDTH = 3,
    parameter int WB_CTRL_WIDTH  = 2,
    parameter int MEM_READ_BIT   = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      stallIn,
    input  logic                      flushIn,
    input  logic                      validInput,
    input  logic                      regDestInput,
    input  logic                      aluSrcInput,
    input  logic [ALU_OP_WIDTH-1:0]   aluOpInput,
    input  logic [MEM_CTRL_WIDTH-1:0] memControlInput,
    input  logic [WB_CTRL_WIDTH-1:0]  wbControlInput,
    input  logic [DATA_WIDTH-1:0]     readData1Input,
    input  logic [DATA_WIDTH-1:0]     readData2Input,
    input  logic [DATA_WIDTH-1:0]     signExtendWireInput,
    input  logic [DATA_WIDTH-1:0]     ifIdInput,
    input  logic [REG_ADDR_WIDTH-1:0] rsInput,
    input  logic [REG_ADDR_WIDTH-1:0] rtInput,
    input  logic [REG_ADDR_WIDTH-1:0] rdInput,
    output logic                      valid,
    output logic                      regDest,
    output logic                      aluSrc,
    output logic [ALU_OP_WIDTH-1:0]   aluOp,
    output logic [MEM_CTRL_WIDTH-1:0] memControlIdEx,
    output logic [WB_CTRL_WIDTH-1:0]  wbControlIdEx,
    output logic [DATA_WIDTH-1:0]     readData1,
    output logic [DATA_WIDTH-1:0]     readData2,
    output logic [DATA_WIDTH-1:0]     signExtendWire,
    output logic [DATA_WIDTH-1:0]     ifId,
    output logic [REG_ADDR_WIDTH-1:0] rs,
    output logic [REG_ADDR_WIDTH-1:0] rt,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      hazardStall,
    output logic [CNT_WIDTH-1:0]      bubbleCount
);

`ifdef ID_EX_HAZARD_EN
    localparam bit HAZARD_EN = 1'b1;
`else
    localparam bit HAZARD_EN = 1'b0;
`endif

    logic load_use;
    logic bubble;

    // A valid load in EX whose destination feeds the instruction now in decode.
    assign load_use = valid && memControlIdEx[MEM_READ_BIT] && (rt != '0) && validInput
                      && ((rt == rsInput) || (rt == rtInput));

    assign hazardStall = HAZARD_EN && load_use && !stallIn && !flushIn;
    assign bubble      = flushIn || hazardStall;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            valid          <= 1'b0;
            regDest        <= 1'b0;
            aluSrc         <= 1'b0;
            aluOp          <= '0;
            memControlIdEx <= '0;
            wbControlIdEx  <= '0;
            readData1      <= '0;
            readData2      <= '0;
            signExtendWire <= '0;
            ifId           <= '0;
            rs             <= '0;
            rt             <= '0;
            rd             <= '0;
            bubbleCount    <= '0;
        end else if (bubble) begin
            // Data fields are left as-is: a bubble is fully described by valid and zeroed controls.
            valid          <= 1'b0;
            regDest        <= 1'b0;
            aluSrc         <= 1'b0;
            aluOp          <= '0;
            memControlIdEx <= '0;
            wbControlIdEx  <= '0;
            rs             <= '0;
            rt             <= '0;
            rd             <= '0;
            if (bubbleCount != '1) begin
                bubbleCount <= bubbleCount + CNT_WIDTH'(1);
            end
        end else if (!stallIn) begin
            valid          <= validInput;
            regDest        <= regDestInput;
            aluSrc         <= aluSrcInput;
            aluOp          <= aluOpInput;
            memControlIdEx <= memControlInput;
            wbControlIdEx  <= wbControlInput;
            readData1      <= readData1Input;
            readData2      <= readData2Input;
            signExtendWire <= signExtendWireInput;
            ifId           <= ifIdInput;
            rs             <= rsInput;
            rt             <= rtInput;
            rd             <= rdInput;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: reference model of the stage contents plus directed vectors with literal expectations.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_id_ex_stage;

    typedef struct packed {
        logic        valid;
        logic        reg_dest;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] sext;
        logic [31:0] ifid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } stage_t;

`ifdef ID_EX_HAZARD_EN
    localparam bit HAZ = 1'b1;
    localparam int HB  = 1;
`else
    localparam bit HAZ = 1'b0;
    localparam int HB  = 0;
`endif

    logic        clock   = 1'b0;
    logic        resetN  = 1'b1;
    logic        stallIn = 1'b0;
    logic        flushIn = 1'b0;
    stage_t      in_s    = '0;
    stage_t      dut_s;
    stage_t      sat_s;
    logic        dut_haz;
    logic        sat_haz;
    logic [15:0] dut_cnt;
    logic [1:0]  sat_cnt;

    stage_t exp_s   = '0;
    int     exp_cnt = 0;
    int     n_chk   = 0;
    int     n_fail  = 0;

    always #5 clock = ~clock;

    id_ex_stage u_dut (
        .clock(clock), .resetN(resetN), .stallIn(stallIn), .flushIn(flushIn),
        .validInput(in_s.valid), .regDestInput(in_s.reg_dest), .aluSrcInput(in_s.alu_src),
        .aluOpInput(in_s.alu_op), .memControlInput(in_s.mem), .wbControlInput(in_s.wb),
        .readData1Input(in_s.rd1), .readData2Input(in_s.rd2),
        .signExtendWireInput(in_s.sext), .ifIdInput(in_s.ifid),
        .rsInput(in_s.rs), .rtInput(in_s.rt), .rdInput(in_s.rd),
        .valid(dut_s.valid), .regDest(dut_s.reg_dest), .aluSrc(dut_s.alu_src),
        .aluOp(dut_s.alu_op), .memControlIdEx(dut_s.mem), .wbControlIdEx(dut_s.wb),
        .readData1(dut_s.rd1), .readData2(dut_s.rd2),
        .signExtendWire(dut_s.sext), .ifId(dut_s.ifid),
        .rs(dut_s.rs), .rt(dut_s.rt), .rd(dut_s.rd),
        .hazardStall(dut_haz), .bubbleCount(dut_cnt)
    );

    id_ex_stage #(.CNT_WIDTH(2)) u_sat (
        .clock(clock), .resetN(resetN), .stallIn(stallIn), .flushIn(flushIn),
        .validInput(in_s.valid), .regDestInput(in_s.reg_dest), .aluSrcInput(in_s.alu_src),
        .aluOpInput(in_s.alu_op), .memControlInput(in_s.mem), .wbControlInput(in_s.wb),
        .readData1Input(in_s.rd1), .readData2Input(in_s.rd2),
        .signExtendWireInput(in_s.sext), .ifIdInput(in_s.ifid),
        .rsInput(in_s.rs), .rtInput(in_s.rt), .rdInput(in_s.rd),
        .valid(sat_s.valid), .regDest(sat_s.reg_dest), .aluSrc(sat_s.alu_src),
        .aluOp(sat_s.alu_op), .memControlIdEx(sat_s.mem), .wbControlIdEx(sat_s.wb),
        .readData1(sat_s.rd1), .readData2(sat_s.rd2),
        .signExtendWire(sat_s.sext), .ifId(sat_s.ifid),
        .rs(sat_s.rs), .rt(sat_s.rt), .rd(sat_s.rd),
        .hazardStall(sat_haz), .bubbleCount(sat_cnt)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Load in EX (memRead is bit 1) whose nonzero rt is read by a valid decode instruction.
    function automatic logic model_haz();
        return HAZ && !stallIn && !flushIn && exp_s.valid && exp_s.mem[1] && (exp_s.rt != 5'd0)
               && in_s.valid && ((exp_s.rt == in_s.rs) || (exp_s.rt == in_s.rt));
    endfunction

    function automatic logic [15:0] exp16();
        return (exp_cnt > 65535) ? 16'hFFFF : 16'(exp_cnt);
    endfunction

    function automatic logic [1:0] exp2();
        return (exp_cnt > 3) ? 2'd3 : 2'(exp_cnt);
    endfunction

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            exp_s   <= '0;
            exp_cnt <= 0;
        end else if (flushIn || model_haz()) begin
            exp_s.valid    <= 1'b0;
            exp_s.reg_dest <= 1'b0;
            exp_s.alu_src  <= 1'b0;
            exp_s.alu_op   <= '0;
            exp_s.mem      <= '0;
            exp_s.wb       <= '0;
            exp_s.rs       <= '0;
            exp_s.rt       <= '0;
            exp_s.rd       <= '0;
            exp_cnt        <= exp_cnt + 1;
        end else if (!stallIn) begin
            exp_s <= in_s;
        end
    end

    always @(negedge clock) begin
        check("stage", 160'(dut_s), 160'(exp_s));
        check("hazardStall", 160'(dut_haz), 160'(model_haz()));
        check("bubbleCount", 160'(dut_cnt), 160'(exp16()));
        check("sat_stage", 160'(sat_s), 160'(exp_s));
        check("sat_bubbleCount", 160'(sat_cnt), 160'(exp2()));
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load_lw(input logic [4:0] rt_reg, input logic [31:0] d1);
        in_s       = '0;
        in_s.valid = 1'b1;
        in_s.mem   = 3'b010;
        in_s.wb    = 2'b11;
        in_s.rs    = 5'd2;
        in_s.rt    = rt_reg;
        in_s.rd1   = d1;
        step();
    endtask

    initial begin
        // Reset with every input driven high
        in_s = '1;
        #1 resetN = 1'b0;
        step();
        step();
        check("rst_valid", 160'(dut_s.valid), 160'(0));
        check("rst_rd1", 160'(dut_s.rd1), 160'(0));
        check("rst_cnt", 160'(dut_cnt), 160'(0));
        check("rst_haz", 160'(dut_haz), 160'(0));
        @(negedge clock);
        resetN = 1'b1;
        in_s = '0;
        in_s.valid = 1'b1;
        in_s.rd1 = 32'h1234;
        step();
        check("first_rd1", 160'(dut_s.rd1), 160'(32'h1234));
        check("first_valid", 160'(dut_s.valid), 160'(1));

        // Load-use on rs
        load_lw(5'd5, 32'h1111);
        in_s = '0;
        in_s.valid = 1'b1;
        in_s.rs = 5'd5;
        in_s.rt = 5'd7;
        in_s.rd = 5'd9;
        in_s.wb = 2'b10;
        in_s.reg_dest = 1'b1;
        in_s.rd1 = 32'h2222;
        #1;
        check("lu_haz", 160'(dut_haz), 160'(HB));
        step();
`ifdef ID_EX_HAZARD_EN
        check("lu_bubble_valid", 160'(dut_s.valid), 160'(0));
        check("lu_bubble_wb", 160'(dut_s.wb), 160'(0));
        check("lu_bubble_rd1", 160'(dut_s.rd1), 160'(32'h1111));
        check("lu_cnt", 160'(dut_cnt), 160'(1));
        check("lu_haz_drop", 160'(dut_haz), 160'(0));
        step();
`endif
        check("lu_dep_valid", 160'(dut_s.valid), 160'(1));
        check("lu_dep_rd1", 160'(dut_s.rd1), 160'(32'h2222));
        check("lu_dep_rd", 160'(dut_s.rd), 160'(9));
        check("lu_dep_cnt", 160'(dut_cnt), 160'(HB));

        // Load into $zero never stalls
        load_lw(5'd0, 32'h3333);
        in_s = '0;
        in_s.valid = 1'b1;
        in_s.rd1 = 32'h4444;
        #1;
        check("zero_haz", 160'(dut_haz), 160'(0));
        step();
        check("zero_valid", 160'(dut_s.valid), 160'(1));
        check("zero_rd1", 160'(dut_s.rd1), 160'(32'h4444));

        // Stall hold for three cycles with changing inputs
        stallIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_s.rd1 = 32'h5000 + 32'(i);
            in_s.valid = 1'b0;
            step();
        end
        check("stall_rd1", 160'(dut_s.rd1), 160'(32'h4444));
        check("stall_valid", 160'(dut_s.valid), 160'(1));
        check("stall_cnt", 160'(dut_cnt), 160'(HB));

        // Flush wins over stall
        flushIn = 1'b1;
        in_s.wb = 2'b11;
        step();
        check("fos_valid", 160'(dut_s.valid), 160'(0));
        check("fos_wb", 160'(dut_s.wb), 160'(0));
        check("fos_rd1", 160'(dut_s.rd1), 160'(32'h4444));
        check("fos_cnt", 160'(dut_cnt), 160'(HB + 1));
        stallIn = 1'b0;
        flushIn = 1'b0;

        // Flush coinciding with a load-use: one bubble only
        load_lw(5'd6, 32'h6666);
        in_s = '0;
        in_s.valid = 1'b1;
        in_s.rs = 5'd6;
        flushIn = 1'b1;
        #1;
        check("fh_haz", 160'(dut_haz), 160'(0));
        step();
        check("fh_cnt", 160'(dut_cnt), 160'(HB + 2));
        flushIn = 1'b0;

        // Stall masks a pending hazard
        load_lw(5'd4, 32'h7777);
        in_s = '0;
        in_s.valid = 1'b1;
        in_s.rt = 5'd4;
        stallIn = 1'b1;
        #1;
        check("sh_haz", 160'(dut_haz), 160'(0));
        stallIn = 1'b0;

        // Reset asserted while a hazard is pending
        load_lw(5'd3, 32'h8888);
        in_s = '0;
        in_s.valid = 1'b1;
        in_s.rt = 5'd3;
        #1;
        check("rh_haz", 160'(dut_haz), 160'(HB));
        #2 resetN = 1'b0;
        #1;
        check("rh_haz_clr", 160'(dut_haz), 160'(0));
        check("rh_valid", 160'(dut_s.valid), 160'(0));
        check("rh_cnt", 160'(dut_cnt), 160'(0));
        step();
        @(negedge clock);
        resetN = 1'b1;

        // Saturation of the 2-bit counter
        in_s = '0;
        flushIn = 1'b1;
        repeat (5) step();
        check("sat_cnt5", 160'(sat_cnt), 160'(3));
        check("main_cnt5", 160'(dut_cnt), 160'(5));
        step();
        check("sat_cnt6", 160'(sat_cnt), 160'(3));
        check("main_cnt6", 160'(dut_cnt), 160'(6));
        flushIn = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Parametrised ID/EX pipeline register for the MIPS pipeline, successor to the fixed-width ID/EX latch. It carries EX/MEM/WB control and decode data into the execute stage. It adds a valid bit, external stall (hold) and flush (bubble), built-in load-use hazard detection with automatic bubble insertion, and a saturating bubble counter. It sits between the register-file/control decode logic and the ALU/forwarding logic.

## Interface
- DATA_WIDTH, 32, width of register operands, sign-extended immediate and PC+4 field
- REG_ADDR_WIDTH, 5, register specifier width
- ALU_OP_WIDTH, 2, aluOp width
- MEM_CTRL_WIDTH, 3, MEM control bundle width
- WB_CTRL_WIDTH, 2, WB control bundle width
- MEM_READ_BIT, 1, index of memRead inside the MEM control bundle
- CNT_WIDTH, 16, bubble counter width

Ports:
- clock  in  1  rising-edge clock
- resetN  in  1  asynchronous, active-low reset
- stallIn  in  1  hold all stage contents
- flushIn  in  1  replace the incoming instruction with a bubble
- validInput  in  1  decode stage holds a real instruction
- regDestInput, aluSrcInput  in  1 each  EX control
- aluOpInput  in  ALU_OP_WIDTH  EX control
- memControlInput  in  MEM_CTRL_WIDTH  MEM control
- wbControlInput  in  WB_CTRL_WIDTH  WB control
- readData1Input, readData2Input, signExtendWireInput, ifIdInput  in  DATA_WIDTH  decode data
- rsInput, rtInput, rdInput  in  REG_ADDR_WIDTH  register specifiers
- valid  out  1  EX stage holds a real instruction
- regDest, aluSrc, aluOp, memControlIdEx, wbControlIdEx  out  matching  registered control
- readData1, readData2, signExtendWire, ifId, rs, rt, rd  out  matching  registered data
- hazardStall  out  1  load-use hazard; upstream must freeze PC and IF/ID
- bubbleCount  out  CNT_WIDTH  number of bubbles inserted since reset

## Operation
- Reset (resetN=0, asynchronous): all outputs are 0, including valid and bubbleCount. Reset is asserted immediately and released at the next clock edge.
- The action on each rising edge is selected in this priority order:
  1. **flushIn=1**: valid, all control outputs, rs, rt and rd are set to 0. Data outputs hold their values. bubbleCount increments.
  2. **stallIn=1**: every register holds. bubbleCount holds.
  3. **hazardStall=1**: same effect as flush (bubble inserted), and bubbleCount increments.
  4. **Otherwise**: every output loads its corresponding input, and valid loads validInput.
- hazardStall is combinational. It is 1 when all of the following are true:
  - valid is 1
  - memControlIdEx[MEM_READ_BIT] is 1
  - rt is not 0
  - validInput is 1
  - rt equals rsInput, or rt equals rtInput
- hazardStall is forced to 0 while stallIn or flushIn is 1.
- A bubble clears memRead in the EX stage. As a result, hazardStall drops in the following cycle, so a single load-use hazard costs exactly one bubble.
- bubbleCount saturates at all-ones and does not wrap.

## Timing
- Latency: 1 cycle from input to output.
- hazardStall is valid in the same cycle as its inputs. Upstream samples it on the same edge that inserts the bubble.
- Simultaneous flushIn and stallIn: flush wins.
- Simultaneous flushIn and hazard: a single bubble is inserted and bubbleCount increments by 1.
- Reset asserted mid-stall or mid-hazard: outputs clear immediately, and hazardStall becomes 0 in the same cycle.
- Register 0 (rt=0) never raises a hazard.

## Configuration
- ID_EX_HAZARD_EN defined: load-use detection and bubble insertion are present as described above.
- ID_EX_HAZARD_EN undefined:
  - hazardStall is tied to 0.
  - Priority 3 is removed.
  - bubbleCount counts flushes only.

## Test plan
- Reset: hold resetN=0 with nonzero inputs -> all outputs are 0. After release, the first edge loads readData1Input=32'h1234 and valid=1.
- Load-use hazard: EX holds a valid lw with rt=5 and memControlIdEx=3'b010; decode has rsInput=5 and validInput=1 -> hazardStall=1. The next edge gives valid=0, controls=0 and bubbleCount=1. hazardStall=0 in the following cycle, and the dependent instruction then loads.
- No hazard on $zero: lw with rt=0 and rsInput=0 -> hazardStall=0 and the instruction loads normally.
- Stall hold: stallIn=1 for 3 cycles with inputs changing -> outputs keep their pre-stall values, and bubbleCount is unchanged.
- Flush over stall: stallIn=1 and flushIn=1 together -> valid=0, wbControlIdEx=0 and bubbleCount increments by 1.
- Saturation: CNT_WIDTH=2, apply 5 flushes -> bubbleCount reads 3 and stays at 3.
